// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU sequencer.
package alu_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bundle between a requester (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(parameter int W = 8) ();

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic         co;
    logic         err;
    logic         busy;
    logic         done;

    modport master (
        output start, op, a, b,
        input  res_lo, res_hi, co, err, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output res_lo, res_hi, co, err, busy, done
    );

endinterface

// File: rtl/alu_sequencer_adder.sv
// Parameterised ripple-carry adder; the only arithmetic resource of the sequencer.
module alu_sequencer_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU: single-pass ADD/SUB, shift-add MUL and restoring DIV,
// all routed through one shared adder.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam int             CW        = $clog2(W) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(W - 1);

    state_t         state_reg, state_next;
    logic [1:0]     op_reg, op_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [W-1:0]   acc_hi_reg, acc_hi_next;
    logic [W-1:0]   acc_lo_reg, acc_lo_next;
    logic [W-1:0]   res_lo_reg, res_lo_next;
    logic [W-1:0]   res_hi_reg, res_hi_next;
    logic           co_reg, co_next;
    logic           err_reg, err_next;
    logic [CW-1:0]  cnt_reg, cnt_next, cnt_inc;

    logic [W-1:0]   add_x, add_y, add_sum;
    logic           add_cin, add_cout;
    logic [W-1:0]   rem_shift;
    logic           accept, is_sub;

    assign accept    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign is_sub    = (op_reg == OP_SUB);
    // Remainder after the {rem, quot} left shift; acc_hi[W-1] is the bit shifted out.
    assign rem_shift = {acc_hi_reg[W-2:0], acc_lo_reg[W-1]};

    // Step counter increment built from toggle logic so the adder stays the only arithmetic.
    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_cnt_inc
            if (gi == 0) begin : g_lsb
                assign cnt_inc[gi] = ~cnt_reg[0];
            end else begin : g_upper
                assign cnt_inc[gi] = cnt_reg[gi] ^ (&cnt_reg[gi-1:0]);
            end
        end
    endgenerate

    alu_sequencer_adder #(.N(W)) u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= OP_ADD;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            co_reg     <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            res_lo_reg <= res_lo_next;
            res_hi_reg <= res_hi_next;
            co_reg     <= co_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        res_lo_next = res_lo_reg;
        res_hi_next = res_hi_reg;
        co_next     = co_reg;
        err_next    = err_reg;
        cnt_next    = cnt_reg;
        add_x       = acc_hi_reg;
        add_y       = '0;
        add_cin     = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    op_next     = bus.op;
                    a_next      = bus.a;
                    b_next      = bus.b;
                    cnt_next    = '0;
                    err_next    = 1'b0;
                    acc_hi_next = '0;
                    if (bus.op == OP_MUL) begin
                        acc_lo_next = bus.b;
                        state_next  = ITER;
                    end else if ((bus.op == OP_DIV) && (|bus.b)) begin
                        acc_lo_next = bus.a;
                        state_next  = ITER;
                    end else begin
                        state_next  = EXEC;
                    end
                end else begin
                    state_next = IDLE;
                end
            end

            EXEC: begin
                state_next = DONE;
                if (op_reg == OP_DIV) begin
                    // Only a zero divisor reaches EXEC with DIV.
                    res_lo_next = '1;
                    res_hi_next = a_reg;
                    co_next     = 1'b0;
                    err_next    = 1'b1;
                end else begin
                    add_x       = a_reg;
                    add_y       = b_reg ^ {W{is_sub}};
                    add_cin     = is_sub;
                    res_lo_next = add_sum;
                    res_hi_next = '0;
                    co_next     = add_cout;
                end
            end

            ITER: begin
                cnt_next = cnt_inc;
                if (op_reg == OP_MUL) begin
                    add_x       = acc_hi_reg;
                    add_y       = acc_lo_reg[0] ? a_reg : '0;
                    acc_hi_next = {add_cout, add_sum[W-1:1]};
                    acc_lo_next = {add_sum[0], acc_lo_reg[W-1:1]};
                end else begin
                    add_x   = rem_shift;
                    add_y   = ~b_reg;
                    add_cin = 1'b1;
                    if (add_cout || acc_hi_reg[W-1]) begin
                        acc_hi_next = add_sum;
                        acc_lo_next = {acc_lo_reg[W-2:0], 1'b1};
                    end else begin
                        acc_hi_next = rem_shift;
                        acc_lo_next = {acc_lo_reg[W-2:0], 1'b0};
                    end
                end
                if (cnt_reg == LAST_STEP) begin
                    state_next  = DONE;
                    res_lo_next = acc_lo_next;
                    res_hi_next = acc_hi_next;
                    co_next     = 1'b0;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.res_lo = res_lo_reg;
    assign bus.res_hi = res_hi_reg;
    assign bus.co     = co_reg;
    assign bus.err    = err_reg;
    assign bus.busy   = (state_reg == EXEC) || (state_reg == ITER);
    assign bus.done   = (state_reg == DONE);

endmodule
